// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } if_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INCR   = 4;

endpackage

// File: rtl/if_perf_cnt.sv
// Saturating counter pair: delivered instructions and memory-stall cycles.
// Counts are updated on each rising edge and clear on asynchronous reset.
module if_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fetch,
  input  logic             i_stall,
  output logic [CNT_W-1:0] o_fetched,
  output logic [CNT_W-1:0] o_stall
);

  logic [CNT_W-1:0] r_fetched;
  logic [CNT_W-1:0] r_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetched <= '0;
      r_stall   <= '0;
    end else begin
      if (i_fetch && (r_fetched != '1)) r_fetched <= r_fetched + 1'b1;
      if (i_stall && (r_stall != '1))   r_stall   <= r_stall + 1'b1;
    end
  end

  assign o_fetched = r_fetched;
  assign o_stall   = r_stall;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem request port, feeds IF/ID.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_stall counter outputs.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instruction,
  output logic              if_valid,
`ifdef IF_PERF_CNT_EN
  output logic [CNT_W-1:0]  perf_fetched,
  output logic [CNT_W-1:0]  perf_stall,
`endif
  output logic              fetch_stall
);

  if_state_t         r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drop_addr;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_instr;
  logic              r_valid;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_br_pc;
  logic              w_outstanding;
  logic              w_unused_br;

  assign w_pc_inc      = r_pc + ADDR_W'(PC_INCR);
  assign w_br_pc       = {branch_addr[ADDR_W-1:2], 2'b00};
  assign w_outstanding = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_unused_br   = ^branch_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_pc_out    <= '0;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
    end else if (branch_taken) begin
      r_pc     <= w_br_pc;
      r_pc_out <= '0;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
      // An unanswered request must still be retired at its original address.
      if (w_outstanding && !imem_ready) begin
        r_state <= S_DROP;
        if (r_state == S_REQ) r_drop_addr <= r_pc;
      end else begin
        r_state <= S_REQ;
      end
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_ready) begin
            r_instr  <= imem_rdata;
            r_pc_out <= w_pc_inc;
            r_valid  <= 1'b1;
            if (freeze) r_state <= S_HOLD;
            else        r_pc    <= w_pc_inc;
          end else begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            r_pc    <= w_pc_inc;
            r_state <= S_REQ;
          end
        end
        S_DROP: if (imem_ready) r_state <= S_REQ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = w_outstanding;
  assign imem_addr   = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign fetch_stall = (r_state == S_REQ) && !imem_ready;
  assign pc_out      = r_pc_out;
  assign instruction = r_instr;
  assign if_valid    = r_valid;

`ifdef IF_PERF_CNT_EN
  logic w_deliver;
  assign w_deliver = (r_state == S_REQ) && imem_ready && !branch_taken;

  if_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_fetch   (w_deliver),
    .i_stall   (fetch_stall),
    .o_fetched (perf_fetched),
    .o_stall   (perf_stall)
  );
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and drives a request/ready instruction-memory port. It presents {PC+4, instruction} plus a valid flag to the IF/ID register. It honours hazard freeze and branch redirects from later stages.

Parameters:
ADDR_W, 32, PC and memory address width (bits)
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
freeze  in  1  hazard stall; hold PC and outputs, issue no new request
branch_taken  in  1  redirect request from EX (single-cycle pulse)
branch_addr  in  ADDR_W  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 and imem_ready=0
imem_ready  in  1  memory response strobe; may assert in the same cycle as imem_req
imem_rdata  in  32  instruction word, valid when imem_ready=1
pc_out  out  ADDR_W  address of delivered instruction + 4, to IF/ID pc_in
instruction  out  32  delivered instruction, to IF/ID instruction_in
if_valid  out  1  pc_out/instruction hold a real instruction this cycle
fetch_stall  out  1  waiting on memory (state REQ, imem_ready=0)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, imem_req=0, pc_out=0, instruction=0, if_valid=0, fetch_stall=0. Counters=0.
- States: IDLE, REQ, HOLD, DROP.
- IDLE: one cycle after reset release -> REQ. No request is issued.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ready=1 and freeze=0: instruction<=imem_rdata, pc_out<=pc+4, if_valid<=1, pc<=pc+4, stay in REQ. This gives back-to-back fetches at one per cycle with a zero-wait memory.
  - imem_ready=1 and freeze=1: capture word into the output registers, set if_valid<=1, pc unchanged, go to HOLD.
  - imem_ready=0: if_valid<=0, instruction<=0, fetch_stall=1.
- HOLD: imem_req=0; outputs held. When freeze falls: pc<=pc+4 -> REQ.
- Freeze while in REQ without ready: request stays outstanding. pc and imem_addr do not change.
- Outputs are registered, so an instruction appears on pc_out/instruction one cycle after the cycle in which imem_ready is sampled.
- Branch priority: branch_taken overrides freeze and every other event in every state.
  - pc<=branch_addr, if_valid<=0, instruction<=0, pc_out<=0.
  - If a request is outstanding and imem_ready=0 in that cycle: go to DROP; the later response is discarded.
  - Otherwise go to REQ at the new PC. A same-cycle ready is discarded.
- DROP: imem_req held at the old address until imem_ready, data ignored -> REQ with the new pc. A second branch in DROP updates pc only.
- PC arithmetic: modulo 2^ADDR_W; pc=32'hFFFF_FFFC increments to 0. Bits [1:0] are forced to 0 on branch_addr load.
- Reset mid-request: abandons the request immediately. Memory must tolerate imem_req dropping.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (CNT_W) and perf_stall (CNT_W). perf_fetched counts delivered instructions (if_valid rising per word). perf_stall counts cycles with fetch_stall=1. Both saturate at all-ones and clear on reset.
- Undefined: ports and logic absent; the remaining behaviour is identical.

Decomposition:
- Package if_pkg: state encoding (IDLE/REQ/HOLD/DROP), NOP_INSTR=32'h0, PC_INCR=4.
- One sub-module, if_perf_cnt: saturating counter pair, instantiated only under IF_PERF_CNT_EN.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> imem_addr 0,4,8; pc_out 4,8,12; instruction 0,4,8 on consecutive cycles after a 1-cycle IDLE.
- Memory with 3-cycle latency -> fetch_stall high for 2 cycles per fetch, imem_addr stable, if_valid pulses once per word.
- freeze asserted in the same cycle as ready at pc=8 -> HOLD; outputs stay pc_out=12 for the freeze duration; next request addr=12 after release.
- branch_taken to 0x100 while a 3-cycle fetch at 0x20 is outstanding -> if_valid=0, the 0x20 data is never output, next imem_addr=0x100, then pc_out=0x104.
- branch_taken with freeze=1 -> redirect still taken; first delivered pc_out=branch_addr+4. Branch to 0xFFFF_FFFC -> next fetch address wraps to 0.
- rst pulled low mid-wait -> imem_req=0 and all outputs 0 asynchronously. With IF_PERF_CNT_EN, counters read 0 after reset and 3 after three fetches.
